// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the hex encoder and the pattern decoder.
// Both blocks use this one code table.
// Patterns are active-low, with bit order {g,f,e,d,c,b,a}.
// Contents:
//   SEG_0..SEG_F  segment codes for hex digits 0..F
//   SEG_BLANK     all segments off
//   state_t       decoder FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup from a segment pattern to a hex nibble.
// Ports:
//   seg_in  in   7  active-low pattern {g,f,e,d,c,b,a}
//   legal   out  1  pattern is one of the 16 digit codes
//   blank   out  1  pattern is all segments off
//   nibble  out  4  decoded value; 0 unless legal
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg_in)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// This block decodes a stream of active-low 7-segment patterns back into hex nibbles.
// It packs NDIG nibbles per output word, with digit 0 in the least-significant bits.
// Each completed word is presented on a valid/ready output.
// Optional feature: define SEG7_ERR_CNT_EN to build a saturating illegal-pattern counter.
// Without it, err_count reads 0.
// Ports:
//   clk, rst    rising-edge clock and synchronous active-high reset
//   seg_in      active-low pattern {g,f,e,d,c,b,a}
//   seg_valid   seg_in is valid this cycle
//   seg_ready   block can accept seg_in; this depends only on the FSM state
//   word_out    packed nibbles (4*NDIG bits)
//   word_valid  word_out is valid
//   word_ready  consumer takes word_out
//   err_pulse   one-cycle pulse after an illegal pattern is accepted
//   err_count   saturating count of illegal patterns
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG  = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic                seg_valid,
  output logic                seg_ready,
  output logic [4*NDIG-1:0]   word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_count
);

  localparam int unsigned WORD_W = 4 * NDIG;
  localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] word_next;
  logic              lk_legal;
  logic              lk_blank;
  logic [3:0]        lk_nibble;
  logic              accept;
  logic              err_set;

  seg7_pattern_lookup u_lookup (
    .seg_in (seg_in),
    .legal  (lk_legal),
    .blank  (lk_blank),
    .nibble (lk_nibble)
  );

  assign seg_ready = (state == COLLECT);
  assign accept    = seg_valid & seg_ready;
  assign err_set   = accept & ~lk_legal & ~lk_blank;

  // Assembly word with the incoming nibble merged into the current slot
  always_comb begin
    word_next = asm_word;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) word_next[4*i +: 4] = lk_nibble;
    end
  end

  // Collect / hold FSM with registered word, valid and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      idx        <= '0;
      asm_word   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept && lk_legal) begin
            asm_word <= word_next;
            if (idx == LAST_IDX) begin
              word_out   <= word_next;
              word_valid <= 1'b1;
              idx        <= '0;
              state      <= HOLD;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (err_set) begin
            // Partial word is abandoned; stale slots are overwritten before reuse
            err_pulse <= 1'b1;
            idx       <= '0;
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SEG7_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt;

  // Counts alongside err_pulse and sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_set && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = '0;
`endif

endmodule
